// File: rtl/pll_serial_rst_seq_if.sv
// Status/control bundle between the serial-link PLL reset sequencer and its surroundings.
// master = sequencer side, slave = PLL/link side.
interface pll_serial_rst_seq_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  pll_locked;
  logic                  force_relock;
  logic                  pll_rst;
  logic                  sys_rst;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;
  logic                  timeout_flag;
  logic [1:0]            state_dbg;

  modport master (
    input  pll_locked, force_relock,
    output pll_rst, sys_rst, ready, lock_loss_cnt, timeout_flag, state_dbg
  );

  modport slave (
    output pll_locked, force_relock,
    input  pll_rst, sys_rst, ready, lock_loss_cnt, timeout_flag, state_dbg
  );
endinterface

// File: rtl/pll_serial_rst_seq.sv
// PLL reset sequencer / lock supervisor on refclk; holds sys_rst until lock is stable.
// Optional PLL_RESET_RETRY_EN: a WAIT_LOCK timeout re-pulses pll_rst instead of parking.
module pll_serial_rst_seq #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 125000,
  parameter int CNT_W            = 20,
  parameter int LOSS_CNT_W       = 8
) (
  input  logic                      refclk,
  input  logic                      rst,
  pll_serial_rst_seq_if.master      bus
);
  localparam logic [1:0] S_PLL_RST   = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);

  // pll_locked is asynchronous to refclk
  logic [1:0] sync_pipe;
  logic       locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], bus.pll_locked};
  end

  assign locked_s = sync_pipe[1];

  logic [1:0]            state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic                  loss_evt, tmo_evt;
  logic [LOSS_CNT_W-1:0] loss_cnt;
  logic                  tmo_flag;
  logic                  pll_rst_q, sys_rst_q, ready_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    loss_evt = 1'b0;
    tmo_evt  = (state == S_WAIT_LOCK) && !locked_s && (cnt == TMO_LAST);
    case (state)
      S_PLL_RST: begin
        if (cnt == RST_LAST) state_nx = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (bus.force_relock)  state_nx = S_PLL_RST;
        else if (locked_s)     state_nx = S_STABLE;
        else if (tmo_evt) begin
`ifdef PLL_RESET_RETRY_EN
          state_nx = S_PLL_RST;
`else
          cnt_nx   = cnt;
`endif
        end
      end
      S_STABLE: begin
        if (bus.force_relock)      state_nx = S_PLL_RST;
        else if (!locked_s)        state_nx = S_WAIT_LOCK;
        else if (cnt == STB_LAST)  state_nx = S_RUN;
      end
      S_RUN: begin
        cnt_nx = cnt;
        // a loss takes precedence over a coincident force_relock so it is counted
        if (!locked_s) begin
          loss_evt = 1'b1;
          state_nx = S_PLL_RST;
        end else if (bus.force_relock) begin
          state_nx = S_PLL_RST;
        end
      end
      default: state_nx = S_PLL_RST;
    endcase
    if (state_nx != state) cnt_nx = '0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= S_PLL_RST;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // outputs decoded from next state so they move on the same edge as state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      pll_rst_q <= (state_nx == S_PLL_RST);
      sys_rst_q <= (state_nx != S_RUN);
      ready_q   <= (state_nx == S_RUN);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (loss_evt && (loss_cnt != '1)) loss_cnt <= loss_cnt + 1'b1;
      if (tmo_evt)                      tmo_flag <= 1'b1;
    end
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst       = sys_rst_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = loss_cnt;
  assign bus.timeout_flag  = tmo_flag;
  assign bus.state_dbg     = state;
endmodule

// File: doc/pll_serial_rst_seq.md
# pll_serial_rst_seq

Reset sequencer and lock supervisor for the serial-link clock PLL. Runs on the free-running 125 MHz reference clock and drives the PLL reset. Watches the PLL lock indication and releases a synchronous reset to the serial-link logic only after lock has been stable. On any loss of lock it re-runs the PLL reset sequence and counts the event.

## Interface
- `RST_PULSE_CYC`, 16: cycles `pll_rst` is held high per reset attempt (≥2).
- `LOCK_STABLE_CYC`, 1024: consecutive cycles of synchronized lock required before release (≥1).
- `LOCK_TIMEOUT_CYC`, 125000: cycles allowed in WAIT_LOCK before timeout (1 ms at 125 MHz).
- `CNT_W`, 20: shared cycle counter width; must hold max(parameters)−1.
- `LOSS_CNT_W`, 8: lock-loss counter width.
- `refclk` in 1: free-running 125 MHz reference clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL lock output, asynchronous to `refclk`.
- `force_relock` in 1: synchronous single-cycle request to re-run the PLL reset.
- `pll_rst` out 1: reset to the PLL, active-high.
- `sys_rst` out 1: reset to serial-link logic, active-high; deasserts synchronously to `refclk`.
- `ready` out 1: high while in RUN.
- `lock_loss_cnt` out LOSS_CNT_W: number of lock losses seen in RUN; saturates at all-ones.
- `timeout_flag` out 1: sticky; set on any WAIT_LOCK timeout.
- `state_dbg` out 2: current state encoding, PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`; both flops reset to 0.
- Single counter `cnt`, cleared on every state entry.
- PLL_RST
  - `pll_rst`=1.
  - After RST_PULSE_CYC cycles, go to WAIT_LOCK.
  - `force_relock` and `locked_s` are ignored here.
- WAIT_LOCK
  - `locked_s`=1 → STABLE.
  - Otherwise `cnt` increments.
  - When `cnt`=LOCK_TIMEOUT_CYC−1 with `locked_s`=0, a timeout occurs: set `timeout_flag` (see Configuration).
- STABLE
  - `locked_s`=0 → WAIT_LOCK.
  - `cnt`=LOCK_STABLE_CYC−1 with `locked_s`=1 → RUN.
- RUN
  - `locked_s`=0 → increment `lock_loss_cnt` (saturating), then PLL_RST.
  - `force_relock`=1 with `locked_s`=1 → PLL_RST, no count.
  - Simultaneous lock loss and `force_relock`: counted as a loss.
- `force_relock` in WAIT_LOCK or STABLE → PLL_RST.
- Outputs are registered and decoded from the next state, so they change in the same cycle as `state_dbg`:
  - `pll_rst` = (state==PLL_RST)
  - `sys_rst` = (state!=RUN)
  - `ready` = (state==RUN)

## Timing
- Reset values:
  - state PLL_RST, `pll_rst`=1, `sys_rst`=1, `ready`=0
  - `lock_loss_cnt`=0, `timeout_flag`=0, `cnt`=0, synchronizer 0
- Reset asserted at any time forces these values immediately, with no glitch on `pll_rst`. Asserting `rst` mid-operation clears `lock_loss_cnt` and `timeout_flag`.
- After `rst` deasserts, `pll_rst` stays high for exactly RST_PULSE_CYC rising edges of `refclk`.
- `pll_locked` rising edge → `locked_s` high 2 cycles later.
  - STABLE is entered on the following edge.
  - RUN is entered LOCK_STABLE_CYC cycles after STABLE entry.
- `locked_s` falling in RUN → `sys_rst`=1 and `pll_rst`=1 on the next edge; `lock_loss_cnt` updates on that same edge.
- `sys_rst` reassertion in RUN is synchronous, so the downstream logic sees a whole-cycle reset.

## Configuration
- `PLL_RESET_RETRY_EN` defined: a WAIT_LOCK timeout sets `timeout_flag` and transitions to PLL_RST, issuing a fresh RST_PULSE_CYC reset pulse. Retries repeat indefinitely.
- Not defined: a timeout sets `timeout_flag`, and `cnt` saturates at LOCK_TIMEOUT_CYC−1. The FSM stays in WAIT_LOCK until `locked_s`=1 or `force_relock`.

## Test plan
All scenarios use RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32.

1. Release `rst`; raise `pll_locked` at cycle 10 and hold it → `pll_rst` high cycles 0–3, `locked_s` high at cycle 12, STABLE at 13, `ready`=1 and `sys_rst`=0 from cycle 21.
2. In STABLE, drop `pll_locked` for 1 cycle after 5 stable cycles → return to WAIT_LOCK; `ready` stays 0; `lock_loss_cnt` stays 0; RUN is reached only after a fresh 8-cycle stable run.
3. In RUN, drop `pll_locked` → `lock_loss_cnt`=1, `pll_rst` pulses 4 cycles, relock restores `ready`. Repeat 300 times with LOSS_CNT_W=8 → count holds at 255.
4. Hold `pll_locked`=0:
   - with `PLL_RESET_RETRY_EN`: `timeout_flag`=1 after 32 WAIT_LOCK cycles, and a new 4-cycle `pll_rst` pulse every 36 cycles.
   - without it: single flag set, `pll_rst` stays 0.
5. `force_relock` pulse in RUN → PLL_RST next edge, `lock_loss_cnt` unchanged. Same cycle as a lock drop → `lock_loss_cnt` increments by exactly 1.
6. Assert `rst` mid-RUN with `lock_loss_cnt`=3 and `timeout_flag`=1 → all outputs return to reset values asynchronously, counters cleared.
